avalon_frame_reader: RTL and testbench

AVALON_FRAME_READER -- requirements
Module: avalon_frame_reader

---
 rtl/avalon_frame_reader_if.sv | 45 ++++
 rtl/avalon_frame_reader.sv | 158 +++++++++++++++
 tb/tb_avalon_frame_reader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_frame_reader_if.sv
// ----------------------------------------------------------------------------
// avalon_frame_reader_if
//   Groups the Avalon-MM burst read bus and the pixel stream of the frame
//   reader.
//
//   Avalon side : avl_address, avl_read, avl_burstbegin, avl_burstcount
//                 (reader -> memory); avl_waitrequest_n, avl_readdata,
//                 avl_readdatavalid (memory -> reader)
//   Pixel side  : oPIX_DATA, oPIX_VALID, oPIX_SOF (reader -> consumer);
//                 iPIX_READY (consumer -> reader)
//
//   master modport : the frame reader
//   slave modport  : memory controller plus pixel consumer
// ----------------------------------------------------------------------------
interface avalon_frame_reader_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avl_address;
    logic              avl_read;
    logic              avl_burstbegin;
    logic [6:0]        avl_burstcount;
    logic              avl_waitrequest_n;
    logic [DATA_W-1:0] avl_readdata;
    logic              avl_readdatavalid;

    logic [DATA_W-1:0] oPIX_DATA;
    logic              oPIX_VALID;
    logic              oPIX_SOF;
    logic              iPIX_READY;

    modport master (
        output avl_address, avl_read, avl_burstbegin, avl_burstcount,
        input  avl_waitrequest_n, avl_readdata, avl_readdatavalid,
        output oPIX_DATA, oPIX_VALID, oPIX_SOF,
        input  iPIX_READY
    );

    modport slave (
        input  avl_address, avl_read, avl_burstbegin, avl_burstcount,
        output avl_waitrequest_n, avl_readdata, avl_readdatavalid,
        input  oPIX_DATA, oPIX_VALID, oPIX_SOF,
        output iPIX_READY
    );
endinterface

// File: rtl/avalon_frame_reader.sv
// ----------------------------------------------------------------------------
// avalon_frame_reader
//   Reads one frame of FRAME_WORDS words from Avalon-MM memory using
//   fixed-length bursts and streams it out through a first-word-fall-through
//   pixel FIFO. A burst is only requested when the FIFO can absorb every word
//   already requested plus the new burst, so the FIFO never overflows while
//   the memory behaves.
//
//   Ports
//     iCLK, iRST_n     : clock, synchronous active-low reset
//     iSTART           : single-cycle frame start request
//     local_init_done  : memory controller calibrated; gates iSTART
//     bus (master)     : Avalon burst read bus and pixel stream
//     oBUSY            : frame in progress
//     oDONE            : whole frame consumed; held until the next start
//     oOVERFLOW        : sticky, a returned word found the FIFO full
// ----------------------------------------------------------------------------
module avalon_frame_reader #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int FRAME_WORDS = 2073600,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  iSTART,
    input  logic                  local_init_done,
    avalon_frame_reader_if.master bus,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oOVERFLOW
);

    localparam int NUM_BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BCNT_W     = $clog2(NUM_BURSTS + 1);
    localparam int PCNT_W     = $clog2(FRAME_WORDS + 1);
    localparam int CRD_W      = CNT_W + 2;

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [BCNT_W-1:0]  burst_cnt;
    logic [PCNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic               overflow_q;

    logic               start_ok, active, accept, last_burst, credit_ok;
    logic               fifo_full, fifo_empty, wr_req, wr_en, rd_en, dec;
    logic               frame_consumed;
    logic [CRD_W-1:0]   committed;

    // Control decodes
    assign start_ok   = (state == IDLE || state == DONE) && iSTART && local_init_done;
    assign active     = (state == ISSUE) || (state == HOLD) || (state == DRAIN);
    assign accept     = (state == HOLD) && bus.avl_waitrequest_n;
    assign last_burst = (burst_cnt == BCNT_W'(NUM_BURSTS - 1));

    // Credit: words already in the FIFO plus words still in flight plus the
    // next burst must all fit, so every returned word has a slot waiting.
    assign committed  = CRD_W'(fifo_count) + CRD_W'(outstanding) + CRD_W'(BURST_LEN);
    assign credit_ok  = (committed <= CRD_W'(FIFO_DEPTH));

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    // Returned data outside a frame (e.g. late words after a reset) is dropped.
    assign wr_req     = bus.avl_readdatavalid && active;
    assign wr_en      = wr_req && !fifo_full;
    assign rd_en      = !fifo_empty && bus.iPIX_READY;
    assign dec        = wr_req && (outstanding != '0);

    assign frame_consumed = (pix_cnt == PCNT_W'(FRAME_WORDS));

    // Outputs
    assign bus.avl_read       = (state == HOLD);
    assign bus.avl_burstbegin = bus.avl_read;
    assign bus.avl_burstcount = 7'(BURST_LEN);
    assign bus.avl_address    = addr_q;
    assign bus.oPIX_VALID     = !fifo_empty;
    assign bus.oPIX_DATA      = fifo_mem[rd_ptr];
    assign bus.oPIX_SOF       = !fifo_empty && (pix_cnt == '0);
    assign oBUSY              = active;
    assign oDONE              = (state == DONE);
    assign oOVERFLOW          = overflow_q;

    // Next-state logic
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        state_next = state;
        case (state)
            IDLE, DONE: if (start_ok)  state_next = ISSUE;
            ISSUE:      if (credit_ok) state_next = HOLD;
            HOLD:       if (accept)    state_next = last_burst ? DRAIN : ISSUE;
            DRAIN:      if (frame_consumed && outstanding == '0) state_next = DONE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!iRST_n) state <= IDLE;
        else         state <= state_next;
    end

    // Datapath: address, burst/pixel counters, credit tracking, FIFO pointers
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            addr_q      <= '0;
            burst_cnt   <= '0;
            pix_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
        end else if (start_ok) begin
            addr_q      <= '0;
            burst_cnt   <= '0;
            pix_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (accept) begin
                addr_q    <= addr_q + ADDR_W'(BURST_LEN);
                burst_cnt <= burst_cnt + BCNT_W'(1);
            end
            // Increment and decrement may coincide; both apply in one step.
            outstanding <= outstanding
                         + (accept ? CNT_W'(BURST_LEN) : CNT_W'(0))
                         - (dec    ? CNT_W'(1)         : CNT_W'(0));

            if (wr_req && fifo_full) overflow_q <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !rd_en)      fifo_count <= fifo_count + CNT_W'(1);
            else if (rd_en && !wr_en) fifo_count <= fifo_count - CNT_W'(1);

            if (rd_en && !frame_consumed) pix_cnt <= pix_cnt + PCNT_W'(1);
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge iCLK) begin
        if (wr_en) fifo_mem[wr_ptr] <= bus.avl_readdata;
    end

endmodule

// File: tb/tb_avalon_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_avalon_frame_reader
//   Directed bench for avalon_frame_reader with a 64-word frame, 16-word
//   bursts and a 64-entry FIFO. A memory model answers each accepted burst
//   two cycles later with data equal to the word address, so pixel k of a
//   frame carries value k. Inputs change on the falling edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_avalon_frame_reader;

    localparam int ADDR_W      = 27;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = 64;
    localparam int BURST_LEN   = 16;
    localparam int FIFO_DEPTH  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, init_done;
    logic busy, done, overflow;

    avalon_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_frame_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS),
        .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start),
        .local_init_done(init_done), .bus(bus.master),
        .oBUSY(busy), .oDONE(done), .oOVERFLOW(overflow)
    );

    // Bench-side drivers of the slave half of the interface
    logic              wrq_n, mdl_rdv, force_rdv, ready;
    logic [DATA_W-1:0] mdl_data, force_data;

    assign bus.avl_waitrequest_n = wrq_n;
    assign bus.avl_readdatavalid = mdl_rdv | force_rdv;
    assign bus.avl_readdata      = force_rdv ? force_data : mdl_data;
    assign bus.iPIX_READY        = ready;

    int errors = 0;
    int checks = 0;

    // Memory model: record accepted commands, queue their response words
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    rsp_t              rsp_q[$];
    logic [ADDR_W-1:0] acc_addr[$];
    int                cyc = 0;

    always @(posedge clk) begin
        if (bus.avl_read && bus.avl_waitrequest_n) begin
            acc_addr.push_back(bus.avl_address);
            for (int i = 0; i < BURST_LEN; i++)
                rsp_q.push_back('{DATA_W'(bus.avl_address) + DATA_W'(i), cyc + 2 + i});
        end
        cyc = cyc + 1;
    end

    // Waitrequest stall injection and hold-stability monitor
    int stall_at   = 0;
    int stall_left = 0;
    int hold_seen  = 0;
    int hold_bad   = 0;

    always @(negedge clk) begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mdl_rdv  = 1'b1;
            mdl_data = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            mdl_rdv  = 1'b0;
            mdl_data = '0;
        end

        if (bus.avl_read && stall_left > 0 && acc_addr.size() == stall_at) begin
            wrq_n      = 1'b0;
            stall_left = stall_left - 1;
            hold_seen  = hold_seen + 1;
            if (bus.avl_address != ADDR_W'(16) || bus.avl_burstcount != 7'd16)
                hold_bad = hold_bad + 1;
        end else begin
            wrq_n = 1'b1;
        end
    end

    // Helpers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Take n pixels with READY=1, checking value and SOF against pixel index.
    task automatic consume(input int n, input int first);
        int got;
        int budget;
        got    = first;
        budget = 0;
        ready  = 1'b1;
        while (got < first + n && budget < 2000) begin
            if (bus.oPIX_VALID) begin
                check("pix_data", bus.oPIX_DATA, 32'(got));
                check("pix_sof", 32'(bus.oPIX_SOF), 32'(got == 0));
                if (got == FRAME_WORDS - 1) check("done_before_last", 32'(done), 32'd0);
                got++;
            end
            budget++;
            tick(1);
        end
        ready = 1'b0;
        check("pix_count", 32'(got), 32'(first + n));
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!done && budget < 50) begin
            budget++;
            tick(1);
        end
        check("done_set", 32'(done), 32'd1);
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_seen;
        int budget;

        rst_n = 1'b0; start = 1'b0; init_done = 1'b0; ready = 1'b0;
        force_rdv = 1'b0; force_data = '0; wrq_n = 1'b1;
        mdl_rdv = 1'b0; mdl_data = '0;

        // Reset state
        tick(3);
        check("rst_read", 32'(bus.avl_read), 32'd0);
        check("rst_addr", 32'(bus.avl_address), 32'd0);
        check("rst_burstcount", 32'(bus.avl_burstcount), 32'd16);
        check("rst_valid", 32'(bus.oPIX_VALID), 32'd0);
        check("rst_sof", 32'(bus.oPIX_SOF), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Start before calibration is ignored
        pulse_start();
        tick(5);
        check("nocal_read", 32'(bus.avl_read), 32'd0);
        check("nocal_busy", 32'(busy), 32'd0);
        check("nocal_cmds", 32'(acc_addr.size()), 32'd0);

        // Frame 1: plain streaming
        init_done = 1'b1;
        acc_addr.delete();
        pulse_start();
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_done_clr", 32'(done), 32'd0);
        consume(FRAME_WORDS, 0);
        wait_done();
        check("f1_cmds", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++)
            check("f1_cmd_addr", 32'(acc_addr[i]), 32'(16 * i));
        check("f1_empty", 32'(bus.oPIX_VALID), 32'd0);

        // Frame 2: waitrequest stall on the second burst, start while busy
        acc_addr.delete();
        stall_at = 1; stall_left = 5; hold_seen = 0; hold_bad = 0;
        pulse_start();
        check("f2_done_clr", 32'(done), 32'd0);
        tick(3);
        pulse_start();
        consume(FRAME_WORDS, 0);
        wait_done();
        check("f2_hold_cycles", 32'(hold_seen), 32'd5);
        check("f2_hold_stable", 32'(hold_bad), 32'd0);
        check("f2_cmds", 32'(acc_addr.size()), 32'd4);
        if (acc_addr.size() > 1) check("f2_cmd1_addr", 32'(acc_addr[1]), 32'd16);

        // Frame 3: long consumer stall, then a forced write into a full FIFO
        acc_addr.delete();
        pulse_start();
        ovf_seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (overflow) ovf_seen = 1;
        end
        check("f3_cmds_le4", 32'(acc_addr.size() <= 4), 32'd1);
        check("f3_no_ovf", 32'(ovf_seen), 32'd0);
        check("f3_head", bus.oPIX_DATA, 32'd0);
        check("f3_head_sof", 32'(bus.oPIX_SOF), 32'd1);
        force_data = 32'hDEAD_BEEF;
        force_rdv  = 1'b1;
        tick(1);
        force_rdv  = 1'b0;
        tick(1);
        check("f3_ovf_set", 32'(overflow), 32'd1);
        check("f3_head_kept", bus.oPIX_DATA, 32'd0);
        consume(FRAME_WORDS, 0);
        wait_done();
        check("f3_ovf_sticky", 32'(overflow), 32'd1);
        check("f3_extra_dropped", 32'(bus.oPIX_VALID), 32'd0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("f3_ovf_rst", 32'(overflow), 32'd0);
        check("f3_done_rst", 32'(done), 32'd0);
        tick(2);

        // Frame 4: reset after 20 pixels, late data afterwards
        acc_addr.delete();
        pulse_start();
        consume(20, 0);
        rst_n = 1'b0;
        tick(2);
        check("f4_rst_valid", 32'(bus.oPIX_VALID), 32'd0);
        check("f4_rst_busy", 32'(busy), 32'd0);
        check("f4_rst_read", 32'(bus.avl_read), 32'd0);
        check("f4_rst_addr", 32'(bus.avl_address), 32'd0);
        rst_n = 1'b1;
        force_data = 32'h0000_1234;
        force_rdv  = 1'b1;
        tick(1);
        force_rdv  = 1'b0;
        budget = 0;
        while (rsp_q.size() > 0 && budget < 100) begin
            budget++;
            tick(1);
        end
        check("f4_mem_drained", 32'(rsp_q.size()), 32'd0);
        tick(2);
        check("f4_late_dropped", 32'(bus.oPIX_VALID), 32'd0);
        check("f4_late_ovf", 32'(overflow), 32'd0);

        // Frame 5: fresh frame after the abandoned one
        acc_addr.delete();
        pulse_start();
        consume(FRAME_WORDS, 0);
        wait_done();
        check("f5_cmds", 32'(acc_addr.size()), 32'd4);
        if (acc_addr.size() > 0) check("f5_cmd0_addr", 32'(acc_addr[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
